// File: rtl/piece_sequencer.sv
// piece_sequencer: game-flow controller for a falling-block game.
// It spawns pieces, paces gravity from the current level, hands finished pieces
// to the line-clear engine, counts cleared lines into levels and detects game over.
// Optional feature: define LOCK_DELAY_EN to add a lock-delay state (LOCK) between
// landing and clearing; without it a landed piece goes straight to CLEAR.
module piece_sequencer #(
    parameter int GRAVITY_INIT    = 48,
    parameter int GRAVITY_DEC     = 4,
    parameter int GRAVITY_MIN     = 4,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LOCK_FRAMES     = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       fell,
    input  logic       spawn_blocked,
    input  logic       clear_done,
    input  logic [2:0] lines_cleared,
    output logic       spawn,
    output logic [2:0] piece_type,
    output logic       drop_step,
    output logic       clear_req,
    output logic       game_over,
    output logic [3:0] level
);

    // One width shared by every frame counter so it fits the longest count.
    localparam int FRAME_MAX = (GRAVITY_INIT > GRAVITY_MIN)
                             ? ((GRAVITY_INIT > LOCK_FRAMES) ? GRAVITY_INIT : LOCK_FRAMES)
                             : ((GRAVITY_MIN  > LOCK_FRAMES) ? GRAVITY_MIN  : LOCK_FRAMES);
    localparam int CW = $clog2(FRAME_MAX + 1);
    // Accumulator never exceeds LINES_PER_LEVEL-1+4 before the level wrap.
    localparam int AW = $clog2(LINES_PER_LEVEL + 5);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
`ifdef LOCK_DELAY_EN
        S_LOCK  = 3'd3,
`endif
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   grav_cnt_r, grav_cnt_s;
    logic [AW-1:0]   acc_r, acc_s;
    logic [3:0]      level_r, level_s;
    logic [2:0]      piece_r, piece_s;
    logic [6:0]      lfsr_r;
`ifdef LOCK_DELAY_EN
    logic [CW-1:0]   lock_cnt_r, lock_cnt_s;
`endif

    logic [31:0]     dec_s;
    logic [31:0]     period_s;
    logic [CW-1:0]   period_m1_s;
    logic            expired_s;
    logic [2:0]      add_s;
    logic [31:0]     sum_s;

    // Shape code from the LFSR: low field, else middle field, else shape 1.
    function automatic logic [2:0] pick_piece(input logic [6:0] v);
        if (v[2:0] != 3'd0) begin
            return v[2:0];
        end else if (v[5:3] != 3'd0) begin
            return v[5:3];
        end else begin
            return 3'd1;
        end
    endfunction

    // Drop period max(INIT - DEC*level, MIN) evaluated without underflow.
    always_comb begin
        dec_s = 32'(GRAVITY_DEC) * {28'd0, level_r};
        if ((dec_s + 32'(GRAVITY_MIN)) < 32'(GRAVITY_INIT)) begin
            period_s = 32'(GRAVITY_INIT) - dec_s;
        end else begin
            period_s = 32'(GRAVITY_MIN);
        end
        period_m1_s = CW'(period_s - 32'd1);
        // >= rather than == so a period that shrank on a level-up cannot be overshot.
        expired_s   = (grav_cnt_r >= period_m1_s);
        add_s       = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        sum_s       = 32'(acc_r) + 32'(add_s);
    end

    // Next-state and output decode; every target starts from its held value.
    always_comb begin
        state_s    = state_r;
        grav_cnt_s = grav_cnt_r;
        acc_s      = acc_r;
        level_s    = level_r;
        piece_s    = piece_r;
        spawn      = 1'b0;
        drop_step  = 1'b0;
        clear_req  = (state_r == S_CLEAR);
        game_over  = (state_r == S_OVER);
`ifdef LOCK_DELAY_EN
        lock_cnt_s = lock_cnt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_SPAWN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SPAWN: begin
                if (spawn_blocked) begin
                    state_s = S_OVER;
                end else begin
                    spawn      = 1'b1;
                    piece_s    = pick_piece(lfsr_r);
                    grav_cnt_s = '0;
                    state_s    = S_FALL;
                end
            end
            S_FALL: begin
                if (fell) begin
`ifdef LOCK_DELAY_EN
                    // The landing frame itself counts as the first lock frame.
                    lock_cnt_s = CW'(1);
                    state_s    = S_LOCK;
`else
                    state_s    = S_CLEAR;
`endif
                end else if (expired_s) begin
                    drop_step  = 1'b1;
                    grav_cnt_s = '0;
                end else begin
                    grav_cnt_s = grav_cnt_r + CW'(1);
                end
            end
`ifdef LOCK_DELAY_EN
            S_LOCK: begin
                if (!fell) begin
                    // Piece slid off its support: resume gravity where it stopped.
                    lock_cnt_s = '0;
                    state_s    = S_FALL;
                end else if (lock_cnt_r >= CW'(LOCK_FRAMES - 1)) begin
                    lock_cnt_s = '0;
                    state_s    = S_CLEAR;
                end else begin
                    lock_cnt_s = lock_cnt_r + CW'(1);
                end
            end
`endif
            S_CLEAR: begin
                if (clear_done) begin
                    if (sum_s >= 32'(LINES_PER_LEVEL)) begin
                        acc_s = AW'(sum_s - 32'(LINES_PER_LEVEL));
                        if (level_r == 4'd15) begin
                            level_s = 4'd15;
                        end else begin
                            level_s = level_r + 4'd1;
                        end
                    end else begin
                        acc_s = AW'(sum_s);
                    end
                    state_s = S_SPAWN;
                end else begin
                    state_s = S_CLEAR;
                end
            end
            S_OVER: begin
                if (start) begin
                    level_s = 4'd0;
                    acc_s   = '0;
                    state_s = S_SPAWN;
                end else begin
                    state_s = S_OVER;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters, level and piece registers; LFSR free-runs every frame.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            grav_cnt_r <= '0;
            acc_r      <= '0;
            level_r    <= 4'd0;
            piece_r    <= 3'd0;
            lfsr_r     <= 7'h5A;
`ifdef LOCK_DELAY_EN
            lock_cnt_r <= '0;
`endif
        end else begin
            state_r    <= state_s;
            grav_cnt_r <= grav_cnt_s;
            acc_r      <= acc_s;
            level_r    <= level_s;
            piece_r    <= piece_s;
            lfsr_r     <= {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
`ifdef LOCK_DELAY_EN
            lock_cnt_r <= lock_cnt_s;
`endif
        end
    end

    assign piece_type = piece_r;
    assign level      = level_r;

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed testbench for piece_sequencer (default parameters).
// Expected latencies follow the build: LOCK_DELAY_EN adds the lock delay.
module tb_piece_sequencer;

`ifdef LOCK_DELAY_EN
    localparam int CLR_LAT = 30;
`else
    localparam int CLR_LAT = 1;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       fell;
    logic       spawn_blocked;
    logic       clear_done;
    logic [2:0] lines_cleared;
    logic       spawn;
    logic [2:0] piece_type;
    logic       drop_step;
    logic       clear_req;
    logic       game_over;
    logic [3:0] level;

    int         n_vec = 0;
    int         n_bad = 0;
    int         k;
    logic [6:0] lfsr_m;
    logic [2:0] exp_piece;

    piece_sequencer dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .start         (start),
        .fell          (fell),
        .spawn_blocked (spawn_blocked),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .spawn         (spawn),
        .piece_type    (piece_type),
        .drop_step     (drop_step),
        .clear_req     (clear_req),
        .game_over     (game_over),
        .level         (level)
    );

    // 10-unit frame clock.
    always #5 frame_clk = ~frame_clk;

    // Reference LFSR x^7+x^6+1 seeded 7'h5A, stepping every frame.
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) lfsr_m <= 7'h5A;
        else       lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    function automatic logic [2:0] ref_piece(input logic [6:0] v);
        if (v[2:0] != 3'd0)      return v[2:0];
        else if (v[5:3] != 3'd0) return v[5:3];
        else                     return 3'd1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 2 units after the next rising edge.
    task automatic tick();
        @(posedge frame_clk);
        #2;
    endtask

    // Count frames until drop_step is seen (bounded).
    task automatic count_drop(output int n);
        n = 0;
        #1;
        while (!drop_step && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Land the piece and count frames until clear_req rises (bounded).
    task automatic fall_to_clear(output int n);
        fell = 1'b1;
        n = 0;
        #1;
        while (!clear_req && n < 100) begin
            tick();
            n++;
        end
        fell = 1'b0;
    endtask

    // Finish a clear of n rows, pass through SPAWN into FALL.
    task automatic do_clear(input logic [2:0] n);
        lines_cleared = n;
        clear_done    = 1'b1;
        tick();
        clear_done    = 1'b0;
        lines_cleared = 3'd0;
        #1;
        check("spawn_after_clear", spawn, 1);
        tick();
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; fell = 1'b0; spawn_blocked = 1'b0;
        clear_done = 1'b0; lines_cleared = 3'd0;
        #3;
        check("rst_spawn", spawn, 0);
        check("rst_drop", drop_step, 0);
        check("rst_clear_req", clear_req, 0);
        check("rst_game_over", game_over, 0);
        check("rst_level", level, 0);
        check("rst_piece", piece_type, 0);
        tick(); tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("idle_no_spawn", spawn, 0);

        // First spawn and level-0 gravity cadence.
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("spawn_pulse", spawn, 1);
        exp_piece = ref_piece(lfsr_m);
        tick();
        check("spawn_one_cycle", spawn, 0);
        check("piece_value", piece_type, exp_piece);
        check("piece_range", (piece_type >= 3'd1 && piece_type <= 3'd7) ? 1 : 0, 1);
        count_drop(k);
        check("drop_first_l0", k, 47);
        tick();
        count_drop(k);
        check("drop_period_l0", k, 47);

        // start is ignored while falling.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("start_ignored", spawn, 0);
        count_drop(k);
        check("drop_resync", k, 46);

        // fell on the expiry frame wins over drop_step.
        fell = 1'b1;
        #1;
        check("fell_wins", drop_step, 0);
        fall_to_clear(k);
        check("clear_latency", k, CLR_LAT);
        tick();
        #1;
        check("clear_req_held", clear_req, 1);

        // Line accounting: 4+4+7(as 4) = 12 -> level 1, acc 2.
        do_clear(3'd4);
        fall_to_clear(k);
        do_clear(3'd4);
        fall_to_clear(k);
        do_clear(3'd7);
        check("level_after_12", level, 1);
        count_drop(k);
        check("drop_period_l1", k, 43);
        fall_to_clear(k);
        do_clear(3'd4);
        fall_to_clear(k);
        do_clear(3'd3);
        check("level_acc_9", level, 1);
        fall_to_clear(k);
        do_clear(3'd1);
        check("level_acc_10", level, 2);
        count_drop(k);
        check("drop_period_l2", k, 39);

`ifdef LOCK_DELAY_EN
        // Brief landing: back to FALL with the gravity count preserved.
        tick();
        repeat (5) tick();
        fell = 1'b1;
        repeat (10) tick();
        #1;
        check("lock_no_clear", clear_req, 0);
        fell = 1'b0;
        tick();
        #1;
        check("unlock_no_clear", clear_req, 0);
        count_drop(k);
        check("drop_after_unlock", k, 34);
`endif

        // Blocked spawn -> game over, then restart clears the level.
        fall_to_clear(k);
        clear_done = 1'b1;
        tick();
        clear_done    = 1'b0;
        spawn_blocked = 1'b1;
        #1;
        check("blocked_no_spawn", spawn, 0);
        tick();
        check("game_over_set", game_over, 1);
        check("level_kept_over", level, 2);
        repeat (3) tick();
        check("game_over_held", game_over, 1);
        spawn_blocked = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("restart_level", level, 0);
        check("restart_game_over", game_over, 0);
        check("restart_spawn", spawn, 1);
        tick();

        // Asynchronous reset in the middle of CLEAR.
        fall_to_clear(k);
        check("clear_before_rst", clear_req, 1);
        #3;
        Reset = 1'b1;
        #1;
        check("async_rst_clear_req", clear_req, 0);
        check("async_rst_piece", piece_type, 0);
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", spawn, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("post_rst_spawn", spawn, 1);
        exp_piece = ref_piece(lfsr_m);
        tick();
        check("post_rst_piece", piece_type, exp_piece);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/piece_sequencer.md
PIECE_SEQUENCER -- requirements
Module: piece_sequencer

Interface
REQ-001 SHALL have parameter GRAVITY_INIT, default 48, frames per one-row drop at level 0.
REQ-002 SHALL have parameter GRAVITY_DEC, default 4, frames removed from the drop period per level.
REQ-003 SHALL have parameter GRAVITY_MIN, default 4, floor of the drop period in frames.
REQ-004 SHALL have parameter LINES_PER_LEVEL, default 10, cleared lines per level increment.
REQ-005 SHALL have parameter LOCK_FRAMES, default 30, lock-delay length in frames (used only with LOCK_DELAY_EN).
REQ-006 SHALL have port frame_clk  in  1  the single clock; all state advances on its rising edge.
REQ-007 SHALL have port Reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port start  in  1  start or restart the game.
REQ-009 SHALL have port fell  in  1  current piece rests on the floor or the stack.
REQ-010 SHALL have port spawn_blocked  in  1  spawn cells are occupied.
REQ-011 SHALL have port clear_done  in  1  line-clear engine finished; qualifies lines_cleared.
REQ-012 SHALL have port lines_cleared  in  3  rows removed by the last clear, 0..4.
REQ-013 SHALL have port spawn  out  1  load a new piece at the spawn position.
REQ-014 SHALL have port piece_type  out  3  shape code 1..7 for the current piece.
REQ-015 SHALL have port drop_step  out  1  one-cycle pulse that advances the piece one row.
REQ-016 SHALL have port clear_req  out  1  request a line-clear pass; held until clear_done.
REQ-017 SHALL have port game_over  out  1  game ended.
REQ-018 SHALL have port level  out  4  current level, 0..15.

Function
REQ-019 SHALL implement the states IDLE, SPAWN, FALL, LOCK, CLEAR and OVER. LOCK is present only with LOCK_DELAY_EN.
REQ-020 SHALL transition IDLE->SPAWN when start=1, and OVER->SPAWN when start=1; on the OVER->SPAWN transition level and the line accumulator SHALL clear.
REQ-021 SHALL make SPAWN last exactly one cycle: spawn_blocked=1 -> OVER; otherwise spawn=1 for that cycle, piece_type latched, gravity counter cleared, -> FALL.
REQ-022 SHALL run a free 7-bit LFSR (x^7+x^6+1, seed 7'h5A) that advances every cycle; latched piece_type = lfsr[2:0] if nonzero, else lfsr[5:3] if nonzero, else 3'd1.
REQ-023 SHALL set the drop period to max(GRAVITY_INIT - GRAVITY_DEC*level, GRAVITY_MIN), computed without underflow.
REQ-024 SHALL, in FALL, increment the gravity counter each cycle; at period-1 it SHALL assert drop_step for one cycle and wrap the counter to 0.
REQ-025 SHALL give priority to fell in FALL: fell=1 moves to LOCK (or CLEAR), with no drop_step that cycle, even when the counter expires in the same cycle.
REQ-026 SHALL, in LOCK, count LOCK_FRAMES cycles: fell=0 -> FALL with the gravity counter preserved; expiry -> CLEAR.
REQ-027 SHALL hold clear_req=1 throughout CLEAR.
REQ-028 SHALL, when clear_done=1 in CLEAR, add min(lines_cleared,4) to the accumulator and then go to SPAWN next cycle.
REQ-029 SHALL, when the accumulator reaches LINES_PER_LEVEL or more, subtract LINES_PER_LEVEL and increment level, saturating at 15.
REQ-030 SHALL hold game_over=1 for as long as the state is OVER.
REQ-031 SHALL ignore clear_done outside CLEAR, start outside IDLE and OVER, and fell outside FALL and LOCK.

Reset
REQ-032 SHALL, while Reset=1, force: state=IDLE, spawn=0, drop_step=0, clear_req=0, game_over=0, level=0, piece_type=0, all counters=0, LFSR=7'h5A.
REQ-033 SHALL, when Reset asserts mid-game (any state), go to IDLE immediately, without waiting for a clock edge.

Configuration
REQ-034 SHALL compile the LOCK state and lock counter in only when macro LOCK_DELAY_EN is defined; otherwise fell=1 in FALL goes directly to CLEAR on the next cycle.

Verification
REQ-035 SHALL cover: Reset, start=1 with spawn_blocked=0 -> spawn pulse 1 cycle, piece_type in 1..7, then drop_step every 48 cycles at level 0.
REQ-036 SHALL cover: fell=1 on the same cycle the gravity counter expires -> no drop_step; with LOCK_DELAY_EN clear_req rises 30 cycles later, without it clear_req rises 1 cycle later.
REQ-037 SHALL cover: with LOCK_DELAY_EN, fell=1 for 10 cycles then 0 -> back in FALL, no clear_req, drop cadence resumes from the preserved count.
REQ-038 SHALL cover: three clears of lines_cleared=4 -> level=1 with accumulator 2; lines_cleared=7 is counted as 4.
REQ-039 SHALL cover: spawn_blocked=1 at SPAWN -> game_over=1, no spawn; then start=1 -> level=0 and spawn pulse.
REQ-040 SHALL cover: Reset pulsed mid-CLEAR between clock edges -> clear_req=0 and state IDLE before the next edge.
